// File: rtl/tpi6523_hs.sv
// tpi6523_hs: parametrised three-port TPI with synchronised pin inputs and a DAV/ACK handshake engine.
// Revision 1.0
`default_nettype none

module tpi6523_hs #(
    parameter int PA_W        = 8,
    parameter int PB_W        = 2,
    parameter int PC_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 16
) (
    input  logic            clock,
    input  logic            _reset,
    input  logic            _cs,
    input  logic            _write,
    input  logic [2:0]      rs,
    input  logic [7:0]      data_in,
    output logic [7:0]      data_out,
    output logic            data_oe,
    input  logic [PA_W-1:0] pa_in,
    output logic [PA_W-1:0] pa_out,
    output logic [PA_W-1:0] pa_oe,
    input  logic [PB_W-1:0] pb_in,
    output logic [PB_W-1:0] pb_out,
    output logic [PB_W-1:0] pb_oe,
    input  logic [PC_W-1:0] pc_in,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_oe,
    output logic            irq_n
);
    localparam logic [2:0] RS_PRA    = 3'd0;
    localparam logic [2:0] RS_PRB    = 3'd1;
    localparam logic [2:0] RS_PRC    = 3'd2;
    localparam logic [2:0] RS_DDRA   = 3'd3;
    localparam logic [2:0] RS_DDRB   = 3'd4;
    localparam logic [2:0] RS_DDRC   = 3'd5;
    localparam logic [2:0] RS_CTRL   = 3'd6;
    localparam logic [2:0] RS_STATUS = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_WAIT_REL = 2'd2
    } hs_state_t;

    logic                             cs_q, cs_dly_q, rd_q;
    logic [2:0]                       rs_q;
    logic [7:0]                       din_q;
    logic [SYNC_STAGES-1:0][PA_W-1:0] pa_sync_q;
    logic [SYNC_STAGES-1:0][PB_W-1:0] pb_sync_q;
    logic [SYNC_STAGES-1:0][PC_W-1:0] pc_sync_q;
    logic [PA_W-1:0]                  pra_q, pra_d, ddra_q, ddra_d;
    logic [PB_W-1:0]                  prb_q, prb_d, ddrb_q, ddrb_d;
    logic [PC_W-1:0]                  prc_q, prc_d, ddrc_q, ddrc_d;
    logic                             hs_en_q, hs_en_d, irq_en_q, irq_en_d;
    logic                             timeout_q, timeout_d, done_q, done_d;
    logic                             dav_q, dav_d, irq_n_q;
    logic [7:0]                       data_out_q, data_out_d;
    logic [TIMEOUT_W-1:0]             cnt_q, cnt_d;
    hs_state_t                        state_q, state_d;

    logic            access, wr_acc, rd_acc, pra_wr, stat_rd, hs_abort;
    logic            busy, ack_sync, to_set, done_set;
    logic [PA_W-1:0] pa_view;
    logic [PB_W-1:0] pb_view;
    logic [PC_W-1:0] pc_view;

    // One access per _cs assertion: the cycle where the registered select falls.
    assign access   = cs_dly_q & ~cs_q;
    assign wr_acc   = access & ~rd_q;
    assign rd_acc   = access & rd_q;
    assign pra_wr   = wr_acc & (rs_q == RS_PRA);
    assign stat_rd  = rd_acc & (rs_q == RS_STATUS);
    assign hs_abort = wr_acc & (rs_q == RS_CTRL) & ~din_q[0];
    assign busy     = (state_q != ST_IDLE);
    assign ack_sync = pc_sync_q[SYNC_STAGES-1][PC_W-1];

    assign pa_view = (pra_q & ddra_q) | (pa_sync_q[SYNC_STAGES-1] & ~ddra_q);
    assign pb_view = (prb_q & ddrb_q) | (pb_sync_q[SYNC_STAGES-1] & ~ddrb_q);
    assign pc_view = (prc_q & ddrc_q) | (pc_sync_q[SYNC_STAGES-1] & ~ddrc_q);

    assign data_oe  = ~_cs & _write;
    assign data_out = data_out_q;
    assign irq_n    = irq_n_q;
    assign pa_out   = pra_q;
    assign pa_oe    = ddra_q;
    assign pb_out   = prb_q;
    assign pb_oe    = ddrb_q;

    always_comb begin
        pc_out = prc_q;
        pc_oe  = ddrc_q;
        if (hs_en_q) begin
            pc_out[PC_W-2] = dav_q;
            pc_oe[PC_W-2]  = 1'b1;
            pc_oe[PC_W-1]  = 1'b0;
        end
    end

    always_comb begin
        pra_d    = pra_q;
        prb_d    = prb_q;
        prc_d    = prc_q;
        ddra_d   = ddra_q;
        ddrb_d   = ddrb_q;
        ddrc_d   = ddrc_q;
        hs_en_d  = hs_en_q;
        irq_en_d = irq_en_q;
        if (wr_acc) begin
            case (rs_q)
                RS_PRA:  pra_d  = PA_W'(din_q);
                RS_PRB:  prb_d  = PB_W'(din_q);
                RS_PRC:  prc_d  = PC_W'(din_q >> (8 - PC_W));
                RS_DDRA: ddra_d = PA_W'(din_q);
                RS_DDRB: ddrb_d = PB_W'(din_q);
                RS_DDRC: ddrc_d = PC_W'(din_q >> (8 - PC_W));
                RS_CTRL: begin
                    hs_en_d  = din_q[0];
                    irq_en_d = din_q[1];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        if (rd_acc) begin
            case (rs_q)
                RS_PRA:    data_out_d = 8'(pa_view);
                RS_PRB:    data_out_d = 8'(pb_view);
                RS_PRC:    data_out_d = 8'(pc_view) << (8 - PC_W);
                RS_DDRA:   data_out_d = 8'(ddra_q);
                RS_DDRB:   data_out_d = 8'(ddrb_q);
                RS_DDRC:   data_out_d = 8'(ddrc_q) << (8 - PC_W);
                RS_CTRL:   data_out_d = {6'b0, irq_en_q, hs_en_q};
                default:   data_out_d = {5'b0, done_q, timeout_q, busy};
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dav_d    = dav_q;
        to_set   = 1'b0;
        done_set = 1'b0;
        if (!hs_en_q || hs_abort) begin
            state_d = ST_IDLE;
            dav_d   = 1'b1;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dav_d = 1'b1;
                    if (pra_wr) begin
                        state_d = ST_WAIT_ACK;
                        dav_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_ACK: begin
                    if (!ack_sync) begin
                        state_d = ST_WAIT_REL;
                        dav_d   = 1'b1;
                        cnt_d   = '0;
                    end else if (&cnt_q) begin
                        state_d = ST_IDLE;
                        dav_d   = 1'b1;
                        to_set  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT_REL: begin
                    if (ack_sync) begin
                        state_d  = ST_IDLE;
                        done_set = 1'b1;
                    end else if (&cnt_q) begin
                        state_d = ST_IDLE;
                        dav_d   = 1'b1;
                        to_set  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    dav_d   = 1'b1;
                end
            endcase
        end
        // A flag event coinciding with the clearing STATUS read keeps the flag set.
        timeout_d = to_set   | (timeout_q & ~stat_rd);
        done_d    = done_set | (done_q & ~stat_rd);
    end

    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            cs_q       <= 1'b1;
            cs_dly_q   <= 1'b1;
            rd_q       <= 1'b1;
            rs_q       <= '0;
            din_q      <= '0;
            pa_sync_q  <= '0;
            pb_sync_q  <= '0;
            pc_sync_q  <= '0;
            pra_q      <= '0;
            prb_q      <= '0;
            prc_q      <= '0;
            ddra_q     <= '0;
            ddrb_q     <= '0;
            ddrc_q     <= '0;
            hs_en_q    <= 1'b0;
            irq_en_q   <= 1'b0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
            dav_q      <= 1'b1;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
            data_out_q <= '0;
            irq_n_q    <= 1'b1;
        end else begin
            cs_q       <= _cs;
            cs_dly_q   <= cs_q;
            rd_q       <= _write;
            rs_q       <= rs;
            din_q      <= data_in;
            pa_sync_q  <= {pa_sync_q[SYNC_STAGES-2:0], pa_in};
            pb_sync_q  <= {pb_sync_q[SYNC_STAGES-2:0], pb_in};
            pc_sync_q  <= {pc_sync_q[SYNC_STAGES-2:0], pc_in};
            pra_q      <= pra_d;
            prb_q      <= prb_d;
            prc_q      <= prc_d;
            ddra_q     <= ddra_d;
            ddrb_q     <= ddrb_d;
            ddrc_q     <= ddrc_d;
            hs_en_q    <= hs_en_d;
            irq_en_q   <= irq_en_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
            dav_q      <= dav_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            data_out_q <= data_out_d;
            irq_n_q    <= ~(irq_en_q & (done_q | timeout_q));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tpi6523_hs.sv
// tb_tpi6523_hs: directed self-checking bench for tpi6523_hs (TIMEOUT_W = 4).
// Revision 1.0
`default_nettype none

module tb_tpi6523_hs;
    logic       clock = 1'b0;
    logic       _reset;
    logic       _cs;
    logic       _write;
    logic [2:0] rs;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] pa_in, pa_out, pa_oe;
    logic [1:0] pb_in, pb_out, pb_oe;
    logic [1:0] pc_in, pc_out, pc_oe;
    logic       irq_n;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    tpi6523_hs #(
        .PA_W(8), .PB_W(2), .PC_W(2), .SYNC_STAGES(2), .TIMEOUT_W(4)
    ) dut (
        .clock(clock), ._reset(_reset), ._cs(_cs), ._write(_write), .rs(rs),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .pa_in(pa_in), .pa_out(pa_out), .pa_oe(pa_oe),
        .pb_in(pb_in), .pb_out(pb_out), .pb_oe(pb_oe),
        .pc_in(pc_in), .pc_out(pc_out), .pc_oe(pc_oe),
        .irq_n(irq_n)
    );

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clock);
        _cs = 1'b0; _write = 1'b0; rs = a; data_in = d;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        _cs = 1'b1; _write = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clock);
        _cs = 1'b0; _write = 1'b1; rs = a;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        d = data_out;
        _cs = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        logic [7:0] exp_rd [8];
        exp_rd = '{8'hFF, 8'h03, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        _reset = 1'b0; _cs = 1'b1; _write = 1'b1; rs = 3'd0; data_in = 8'h00;
        pa_in = 8'hFF; pb_in = 2'b11; pc_in = 2'b11;
        repeat (3) @(negedge clock);
        checks++; if ({pa_oe, pb_oe, pc_oe} !== 12'h000) begin failures++; $display("FAIL reset_oe got=%h exp=000", {pa_oe, pb_oe, pc_oe}); end
        checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL reset_irq got=%b exp=1", irq_n); end
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
        _reset = 1'b1;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), v);
            checks++; if (v !== exp_rd[i]) begin failures++; $display("FAIL reset_read rs=%0d got=%h exp=%h", i, v, exp_rd[i]); end
        end
        @(negedge clock);
        _cs = 1'b0; _write = 1'b1; #1;
        checks++; if (data_oe !== 1'b1) begin failures++; $display("FAIL data_oe_read got=%b exp=1", data_oe); end
        _write = 1'b0; #1;
        checks++; if (data_oe !== 1'b0) begin failures++; $display("FAIL data_oe_write got=%b exp=0", data_oe); end
        _cs = 1'b1; _write = 1'b1;
    endtask

    task automatic test_ports();
        logic [7:0] v;
        pa_in = 8'h3C; pb_in = 2'b01; pc_in = 2'b11;
        bus_write(3'd3, 8'h0F);
        bus_write(3'd0, 8'hA5);
        checks++; if (pa_out !== 8'hA5) begin failures++; $display("FAIL pa_out got=%h exp=a5", pa_out); end
        checks++; if (pa_oe !== 8'h0F) begin failures++; $display("FAIL pa_oe got=%h exp=0f", pa_oe); end
        bus_read(3'd0, v);
        checks++; if (v !== 8'h35) begin failures++; $display("FAIL pra_read got=%h exp=35", v); end
        bus_write(3'd4, 8'hFF);
        bus_write(3'd1, 8'h02);
        checks++; if ({pb_oe, pb_out} !== 4'b1110) begin failures++; $display("FAIL pb_pins got=%b exp=1110", {pb_oe, pb_out}); end
        bus_read(3'd4, v);
        checks++; if (v !== 8'h03) begin failures++; $display("FAIL ddrb_read got=%h exp=03", v); end
        bus_read(3'd1, v);
        checks++; if (v !== 8'h02) begin failures++; $display("FAIL prb_read got=%h exp=02", v); end
        bus_write(3'd5, 8'h80);
        bus_write(3'd2, 8'h40);
        checks++; if ({pc_oe, pc_out} !== 4'b1001) begin failures++; $display("FAIL pc_pins got=%b exp=1001", {pc_oe, pc_out}); end
        bus_read(3'd2, v);
        checks++; if (v !== 8'h40) begin failures++; $display("FAIL prc_read got=%h exp=40", v); end
        bus_read(3'd5, v);
        checks++; if (v !== 8'h80) begin failures++; $display("FAIL ddrc_read got=%h exp=80", v); end
    endtask

    task automatic test_handshake();
        logic [7:0] v;
        int n;
        pc_in = 2'b11;
        bus_write(3'd6, 8'h03);
        checks++; if ({pc_oe, pc_out} !== 4'b0101) begin failures++; $display("FAIL hs_pins_idle got=%b exp=0101", {pc_oe, pc_out}); end
        bus_read(3'd6, v);
        checks++; if (v !== 8'h03) begin failures++; $display("FAIL ctrl_read got=%h exp=03", v); end
        bus_write(3'd0, 8'h42);
        checks++; if ({pa_out, pc_out[0]} !== 9'h084) begin failures++; $display("FAIL hs_dav_fall got=%h exp=084", {pa_out, pc_out[0]}); end
        repeat (5) @(negedge clock);
        checks++; if (pc_out[0] !== 1'b0) begin failures++; $display("FAIL hs_dav_hold got=%b exp=0", pc_out[0]); end
        pc_in[1] = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (pc_out[0] === 1'b1) begin n = i; break; end
        end
        checks++; if (n != 3) begin failures++; $display("FAIL hs_ack_latency got=%0d exp=3", n); end
        bus_read(3'd7, v);
        checks++; if (v !== 8'h01) begin failures++; $display("FAIL hs_status_busy got=%h exp=01", v); end
        pc_in[1] = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (irq_n === 1'b0) begin n = i; break; end
        end
        checks++; if (n != 4) begin failures++; $display("FAIL hs_irq_latency got=%0d exp=4", n); end
        bus_read(3'd7, v);
        checks++; if (v !== 8'h04) begin failures++; $display("FAIL hs_status_done got=%h exp=04", v); end
        checks++; if (irq_n !== 1'b0) begin failures++; $display("FAIL hs_irq_still_low got=%b exp=0", irq_n); end
        @(negedge clock);
        checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL hs_irq_release got=%b exp=1", irq_n); end
        bus_read(3'd7, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL hs_status_cleared got=%h exp=00", v); end
    endtask

    task automatic test_timeout();
        logic [7:0] v;
        int n;
        pc_in = 2'b11;
        bus_write(3'd0, 8'h11);
        checks++; if (pc_out[0] !== 1'b0) begin failures++; $display("FAIL to_dav_fall got=%b exp=0", pc_out[0]); end
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (pc_out[0] === 1'b1) begin n = i; break; end
        end
        checks++; if (n != 16) begin failures++; $display("FAIL to_cycles got=%0d exp=16", n); end
        @(negedge clock);
        checks++; if (irq_n !== 1'b0) begin failures++; $display("FAIL to_irq got=%b exp=0", irq_n); end
        bus_read(3'd7, v);
        checks++; if (v !== 8'h02) begin failures++; $display("FAIL to_status got=%h exp=02", v); end
        @(negedge clock);
        checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL to_irq_release got=%b exp=1", irq_n); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        int n;
        pc_in = 2'b11;
        @(negedge clock);
        _cs = 1'b0; _write = 1'b0; rs = 3'd0; data_in = 8'h55;
        repeat (10) @(negedge clock);
        checks++; if ({pa_out, pc_out[0]} !== 9'h0AA) begin failures++; $display("FAIL b2b_first got=%h exp=0aa", {pa_out, pc_out[0]}); end
        _cs = 1'b1; _write = 1'b1;
        bus_write(3'd0, 8'h66);
        checks++; if ({pa_out, pc_out[0]} !== 9'h0CC) begin failures++; $display("FAIL b2b_second got=%h exp=0cc", {pa_out, pc_out[0]}); end
        n = 0;
        for (int i = 14; i <= 40; i++) begin
            @(negedge clock);
            if (pc_out[0] === 1'b1) begin n = i; break; end
        end
        checks++; if (n != 18) begin failures++; $display("FAIL b2b_single_start got=%0d exp=18", n); end
        bus_read(3'd7, v);
        checks++; if (v !== 8'h02) begin failures++; $display("FAIL b2b_status got=%h exp=02", v); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        int n;
        pc_in = 2'b11;
        bus_write(3'd0, 8'h21);
        repeat (2) @(negedge clock);
        checks++; if ({pc_oe[0], pc_out[0]} !== 2'b10) begin failures++; $display("FAIL rm_wait_ack got=%b exp=10", {pc_oe[0], pc_out[0]}); end
        _reset = 1'b0; #1;
        checks++; if ({pa_oe, pb_oe, pc_oe} !== 12'h000) begin failures++; $display("FAIL rm_oe got=%h exp=000", {pa_oe, pb_oe, pc_oe}); end
        checks++; if ({irq_n, data_out} !== 9'h100) begin failures++; $display("FAIL rm_irq_data got=%h exp=100", {irq_n, data_out}); end
        @(negedge clock);
        _reset = 1'b1;
        bus_read(3'd7, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL rm_status got=%h exp=00", v); end
        bus_read(3'd6, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL rm_ctrl got=%h exp=00", v); end
        bus_write(3'd6, 8'h03);
        bus_write(3'd0, 8'h77);
        checks++; if ({pc_oe[0], pc_out[0]} !== 2'b10) begin failures++; $display("FAIL rm_dav_fall got=%b exp=10", {pc_oe[0], pc_out[0]}); end
        pc_in[1] = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (pc_out[0] === 1'b1) begin n = i; break; end
        end
        checks++; if (n != 3) begin failures++; $display("FAIL rm_ack_latency got=%0d exp=3", n); end
        pc_in[1] = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (irq_n === 1'b0) begin n = i; break; end
        end
        checks++; if (n != 4) begin failures++; $display("FAIL rm_irq_latency got=%0d exp=4", n); end
        bus_read(3'd7, v);
        checks++; if (v !== 8'h04) begin failures++; $display("FAIL rm_status_done got=%h exp=04", v); end
    endtask

    initial begin
        test_reset();
        test_ports();
        test_handshake();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

`default_nettype wire

// File: doc/tpi6523_hs.md
# tpi6523_hs

Parametrised, fully synchronous successor to the fake 6523 TPI used in the TCBM paddle. It holds configurable-width ports A, B and C with data-direction registers and synchronised input pins. It adds a hardware DAV/ACK four-phase handshake engine with timeout, a control/status register pair, and an active-low interrupt. It sits behind the PLA-style address decode: the host bus drives `_cs`, `_write`, `rs` and `data_in`, and port pins leave through split in/out/oe buses to pad tristates.

## Interface
- `PA_W`, 8: port A width, 1..8, occupies `data[PA_W-1:0]`.
- `PB_W`, 2: port B width, 1..8, LSB-aligned, `data[PB_W-1:0]`.
- `PC_W`, 2: port C width, 2..8, MSB-aligned, `data[7:8-PC_W]`.
- `SYNC_STAGES`, 2: flops in each pin-input synchroniser, ≥2.
- `TIMEOUT_W`, 16: handshake timeout counter width.

- `clock` in 1: system clock; all state changes on its rising edge.
- `_reset` in 1: asynchronous active-low reset.
- `_cs` in 1: chip select, active low, from the address decode.
- `_write` in 1: 0 = write, 1 = read.
- `rs` in 3: register select.
- `data_in` in 8: host write data.
- `data_out` out 8: registered host read data.
- `data_oe` out 1: `!_cs & _write`, combinational, for the data-bus tristate.
- `pa_in`/`pa_out`/`pa_oe` in/out/out PA_W: port A pins.
- `pb_in`/`pb_out`/`pb_oe` in/out/out PB_W: port B pins.
- `pc_in`/`pc_out`/`pc_oe` in/out/out PC_W: port C pins. Index `PC_W-2` is DAV and `PC_W-1` is ACK in handshake mode.
- `irq_n` out 1: interrupt, active low, registered.

## Operation
- **Access detect:** `_cs` is registered; an access fires in the single cycle where the registered value goes 1→0. There is exactly one access per `_cs` assertion, latching `rs`, `_write` and `data_in` at that edge.
- **Register map (rs):**
  - 0 PRA, 1 PRB, 2 PRC (port registers).
  - 3 DDRA, 4 DDRB, 5 DDRC (1 = output).
  - 6 CTRL: bit0 HS_EN, bit1 IRQ_EN; other bits read 0.
  - 7 STATUS: bit0 BUSY, bit1 TIMEOUT (sticky), bit2 DONE (sticky). Writes to STATUS are ignored.
- **Pin reads:** PRx returns `(PRx & DDRx) | (x_sync & ~DDRx)`, where `x_sync` is the pin input after `SYNC_STAGES` flops. Bits outside a port's width read 0. DDR and CTRL reads return the register value.
- **STATUS read:** returns the current value and clears TIMEOUT and DONE in the same access cycle. A flag event in that same cycle wins: the flag stays set.
- **Pin outputs:** `x_out = PRx`, `x_oe = DDRx`, except in handshake mode as below.
- **Handshake mode (HS_EN=1):**
  - `pc_oe[PC_W-2]` is forced 1 and `pc_out[PC_W-2]` = DAV.
  - `pc_oe[PC_W-1]` is forced 0.
  - DDRC and PRC still hold their written values for those bits but do not drive them.
- **Handshake FSM:** states IDLE, WAIT_ACK, WAIT_REL.
  - IDLE: DAV=1. A write to PRA moves to WAIT_ACK, sets DAV=0 and clears the counter.
  - WAIT_ACK: when synced ACK=0, move to WAIT_REL, set DAV=1 and clear the counter.
  - WAIT_REL: when synced ACK=1, move to IDLE and set DONE.
  - Timeout: in either wait state, the counter increments each cycle. On reaching all-ones, go to IDLE with DAV=1 and set TIMEOUT.
  - PRA written while BUSY: PRA updates, the FSM is not restarted and no flag changes.
  - CTRL write clearing HS_EN while BUSY: FSM goes to IDLE next cycle and no flags are set.
  - BUSY = (state != IDLE).
- **Interrupt:** `irq_n` is registered: `!(IRQ_EN & (DONE | TIMEOUT))`.

## Timing
- **Reset values:** all PR/DDR/CTRL/STATUS = 0 (all pins input, all `*_oe` = 0). FSM in IDLE, counter 0, `data_out` = 0, `irq_n` = 1, synchronisers 0.
- **Read latency:** `data_out` is valid 1 cycle after the access-detect cycle, i.e. 2 clocks after `_cs` falls, and is held until the next read access.
- **Write latency:** a register write is visible on pins 1 cycle after the access-detect cycle.
- **Handshake latency:** DAV falls 1 cycle after the PRA-write access. ACK response latency is `SYNC_STAGES` + 1 cycles.
- **Timeout:** DAV returns high `2^TIMEOUT_W` cycles after entering a wait state if ACK never responds.
- **irq_n:** asserts 1 cycle after DONE/TIMEOUT sets and deasserts 1 cycle after the STATUS read clears them.
- **Reset mid-handshake:** `_reset` low at any time immediately forces all reset values, with DAV undriven.

## Test plan
- Reset, then read every rs 0..7 with all pins driven 0xFF → DDR/CTRL/STATUS read 0x00; PRA=0xFF, PRB=0x03, PRC=0xC0; all `*_oe` = 0.
- Write DDRA=0x0F, PRA=0xA5, pins `pa_in`=0x3C → `pa_out`=0xA5, `pa_oe`=0x0F; PRA reads 0x35.
- HS_EN=1, IRQ_EN=1, write PRA=0x42, bench ACKs after 5 cycles and releases after 3 → DAV low then high; STATUS reads 0x04, `irq_n` low; second STATUS read returns 0x00 and `irq_n` goes high.
- `TIMEOUT_W`=4, HS_EN=1, write PRA with ACK held 1 → DAV high again after 16 cycles; STATUS=0x02.
- Hold `_cs` low for 10 cycles during a write to PRA → exactly one handshake starts; a second PRA write while BUSY updates `pa_out` but leaves DAV low.
- Assert `_reset` in WAIT_ACK → DAV undriven, STATUS=0; after release a fresh PRA write (HS_EN set again) completes normally.
